// File: rtl/serial_byte_tx.sv
// serial_byte_tx: valid/ready byte in, start/LSB-first data/stop frame out on so (idle 1); define SERIAL_TX_PARITY_EN to add an even-parity bit after the data
module serial_byte_tx #(
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              so,
  output logic              busy,
  output logic              frame_done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] AFTER_DATA = PARITY;
  logic par_q, par_d;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic so_q, so_d, din_ready_q, din_ready_d, busy_q, busy_d, frame_done_q, frame_done_d;
  logic xfer, bit_end;
  assign xfer = din_ready_q && din_valid;
  assign bit_end = cnt_q == CNT_MAX;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shreg_d = shreg_q;
    cnt_d = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (xfer) begin
        state_d = START;
        shreg_d = din;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shreg_d = shreg_q >> 1;
        bit_d = bit_q == DATA_LAST ? '0 : bit_q + 1'b1;
        state_d = bit_q == DATA_LAST ? AFTER_DATA : DATA;
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) begin
        bit_d = bit_q == STOP_LAST ? '0 : bit_q + 1'b1;
        state_d = bit_q == STOP_LAST ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
`ifdef SERIAL_TX_PARITY_EN
    par_d = xfer ? ^din : par_q;
    so_d = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : state_d == PARITY ? par_q : 1'b1;
`else
    so_d = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : 1'b1;
`endif
    din_ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
    frame_done_d = state_d == STOP && cnt_d == CNT_MAX && bit_d == STOP_LAST;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shreg_q <= '0;
      so_q <= 1'b1;
      din_ready_q <= 1'b0;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shreg_q <= shreg_d;
      so_q <= so_d;
      din_ready_q <= din_ready_d;
      busy_q <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  assign din_ready = din_ready_q;
  assign so = so_q;
  assign busy = busy_q;
  assign frame_done = frame_done_q;
endmodule

// File: doc/serial_byte_tx.md
Name: serial_byte_tx

Overview:
- Parallel-to-serial frame transmitter with a valid/ready byte handshake and a programmable bit period.
- Sits directly upstream of the team's serial-in shift registers (SIPO/SISO) and drives their si input.
- Wraps each byte in a start bit and stop bit(s), so the downstream stage can frame and reassemble bytes.

Parameters:
- DATA_W, 8, payload bits per frame.
- CLKS_PER_BIT, 4, clk cycles each serial bit is held; legal range is 1 or more.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- din  input  DATA_W  byte to transmit; sampled on handshake.
- din_valid  input  1  upstream has a byte on din.
- din_ready  output  1  block can accept a byte this cycle.
- so  output  1  serial line; idle level 1.
- busy  output  1  a frame is in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Interface decided: one clock (clk); reset rst is synchronous and active-high.
- Reset values: so=1, din_ready=0 during rst, busy=0, frame_done=0, FSM=IDLE, counters=0. din_ready=1 from the first cycle after rst deasserts.
- Handshake:
  - Transfer occurs on a clk edge where din_valid and din_ready are both 1.
  - din_ready=1 only in IDLE; it is a registered output.
  - din is latched into an internal shift register at the transfer edge.
  - din_valid without din_ready is held off, with no loss and no partial capture.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE -> START on transfer.
  - START holds so=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA drives so=shreg[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. At the end of each bit period the shift register shifts right and the bit counter increments. After DATA_W bits -> PARITY if enabled, else STOP.
  - STOP holds so=1 for STOP_BITS*CLKS_PER_BIT cycles; frame_done pulses in the last cycle, then -> IDLE.
- Latency:
  - so falls to 0 in the cycle after the transfer edge.
  - Frame length is (1+DATA_W+STOP_BITS[+1 with parity])*CLKS_PER_BIT cycles; default 40 cycles.
  - din_ready returns to 1 in the cycle after the frame_done pulse.
  - Back-to-back frames therefore have exactly one idle-high cycle between the last stop bit and the next start bit.
- Counters:
  - Bit-period counter is wide enough for CLKS_PER_BIT-1 and wraps to 0 at the end of each bit.
  - Bit counter is wide enough for DATA_W.
  - CLKS_PER_BIT=1 must work, giving one bit per cycle.
- Boundary cases:
  - rst mid-frame aborts immediately: so=1, FSM=IDLE, and the latched byte is discarded.
  - Changes on din or din_valid while busy are ignored.
  - din_valid held high continuously sends consecutive frames with the gap defined above.
- so is registered and glitch-free, driven directly from a flop.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: a PARITY state after DATA drives the even-parity bit (XOR of all DATA_W bits of the latched byte) for CLKS_PER_BIT cycles. Frame length grows by CLKS_PER_BIT.
- Undefined: no PARITY state; DATA goes directly to STOP. No parity logic is synthesised.

Test Plan:
- Reset: assert rst for 3 cycles mid-frame -> so=1, busy=0, frame_done=0, din_ready=0 while rst is high and 1 in the first cycle after release.
- Single byte 8'hA5, CLKS_PER_BIT=4:
  - so sequence, each bit held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
  - frame_done pulses at cycle 40 after the transfer.
  - A downstream SIPO sampling mid-bit reassembles 8'hA5.
- Back-to-back: din_valid held high with 8'h00 then 8'hFF -> second start bit begins exactly 2 cycles after the first frame_done pulse (1 idle cycle). No byte is lost or duplicated.
- Backpressure: change din to 8'h3C while busy with 8'h81 -> the transmitted frame still carries 8'h81; 8'h3C is taken only at the next din_ready.
- CLKS_PER_BIT=1, STOP_BITS=2, byte 8'h01 -> so = 0,1,0,0,0,0,0,0,0,1,1 on consecutive cycles; busy is high for 11 cycles.
- With SERIAL_TX_PARITY_EN, bytes 8'h07 and 8'h03 -> parity bit is 1 for 8'h07 and 0 for 8'h03; frame length is 44 cycles at the defaults.
